b2m_sram_arbiter: RTL and testbench
===================================

# b2m_sram_arbiter

Shares the single 16-bit board SRAM between the 8080 CPU port and the video line-fetch DMA in the Bashkiria-2M replica. Sequences each video fetch as a fixed slot, gates the CPU clock-enable so no CPU bus cycle overlaps a slot, and defers at most one CPU tick lost to a slot. Sits between the CPU/memory-map logic, `b2m_video` and the SRAM pins in the top level.

## Interface

**Parameters**

- `RD_WAIT`, default 1: number of READ cycles in a video slot, range 1..3. Data is captured on the last one.

**Ports**

- `clk50` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `vid_drq` in 1: video fetch request, level. A rising edge requests one slot.
- `vid_addr` in 14: video word address.
- `vid_scroll` in 8: added to `vid_addr[7:0]`.
- `vid_page` in 1: video bank select, SRAM address bit 14.
- `vid_data` out 16: captured video word. Reset 0.
- `vid_busy` out 1: high in any non-IDLE state. Reset 0.
- `cpu_tick` in 1: raw CPU clock-enable from the divider, single-cycle pulses.
- `cpu_ce` out 1: gated CPU clock-enable. Reset 0.
- `cpu_addr` in 18: mapped CPU SRAM word address.
- `cpu_msb` in 1: byte lane select. 1 = DQ[15:8].
- `cpu_rd` in 1: CPU memory read.
- `cpu_wr` in 1: CPU memory write, active-high, already qualified by memory/port select.
- `cpu_dout` in 8: CPU write data.
- `cpu_din` out 8: selected SRAM byte, combinational.
- `sram_dq_i` in 16: SRAM data in.
- `sram_dq_o` out 16: SRAM data out. `cpu_dout` is replicated on both bytes.
- `sram_dq_oe_hi` out 1, `sram_dq_oe_lo` out 1: per-byte output drive enables. Reset 0.
- `sram_addr` out 18: SRAM address.
- `sram_ub_n` out 1, `sram_lb_n` out 1: byte masks.
- `sram_we_n` out 1: write enable. Reset 1.
- `sram_oe_n` out 1: output enable. Reset 1.

## Operation

- **FSM states:** IDLE → SETUP → READ (RD_WAIT cycles, via a down-counter) → HOLD → IDLE.
- **Edge detect:** `vid_drq_q` registers `vid_drq`. `edge = vid_drq & ~vid_drq_q`.
- **Video pending:** `vpend` is set by `edge` in any state other than IDLE. In IDLE, `edge | vpend` moves the FSM to SETUP and clears `vpend`. A second edge while `vpend` is already set is dropped.
- **CPU tick pending:** `tpend` is set by `cpu_tick` when the state is not IDLE.
- **CPU enable:** in IDLE, `cpu_ce = cpu_tick | tpend`. `tpend` clears when `cpu_ce` fires. `cpu_ce` is 0 in every other state. A tick arriving while `tpend` is already set is dropped.
- **Simultaneous events in IDLE:** a video start and `cpu_ce` may coincide. The CPU cycle completes in that IDLE cycle and the slot starts on the next cycle.
- **Address mux:** in READ, `sram_addr = {3'b000, vid_page, vid_addr[13:8], (vid_addr[7:0] + vid_scroll) mod 256}`. The low-byte add wraps with no carry into bit 8. In every other state, `sram_addr = cpu_addr`.
- **Byte masks:**
  - READ: `ub_n = lb_n = 0`.
  - Otherwise: `ub_n = ~cpu_msb`, `lb_n = cpu_msb`.
- **Write strobe:** `sram_we_n = ~(cpu_wr & state==IDLE)`.
  - `dq_oe_hi = ~we_n & cpu_msb`.
  - `dq_oe_lo = ~we_n & ~cpu_msb`.
- **Output enable:** `sram_oe_n = ~(state==READ | (cpu_rd & state==IDLE))`.
- **Video capture:** `vid_data <= sram_dq_i` on the final READ cycle.
- **CPU read data:** `cpu_din = cpu_msb ? sram_dq_i[15:8] : sram_dq_i[7:0]`.
- **Reset mid-slot:** the FSM returns to IDLE. `vpend`, `tpend` and `vid_drq_q` clear, and `vid_data` goes to 0. The interrupted fetch is not replayed.

## Timing

- **Slot length:** 3 + RD_WAIT cycles (4 at default).
- **Video latency:** `vid_drq` edge at cycle 0 (IDLE) → SETUP at 1 → READ at 2 → `vid_data` valid from cycle 3 (default).
- **CPU deferral:** a deferred tick fires in the first IDLE cycle after HOLD, unless a pending video request restarts the slot. In that case `cpu_ce` still fires in that IDLE cycle, alongside the transition to SETUP.
- **Write safety:** the SRAM is never written in SETUP, READ or HOLD. The address and the write strobe change in the same cycle only at an IDLE boundary.

## Configuration

- **`B2M_ARB_STATS_EN` defined:** adds two outputs, reset 0:
  - `stat_drop` out 8: saturating count of dropped CPU ticks plus dropped video edges.
  - `stat_stall` out 16: wrapping count of cycles with `tpend` = 1.
- **Undefined:** neither port nor counter exists, and behaviour is otherwise identical.

## Test plan

- **Reset:** assert `reset` mid-READ → next edge sees IDLE; `vid_data` = 0; `sram_we_n` = 1; `cpu_ce` = 0; no fetch replayed.
- **Video fetch with scroll wrap:** `vid_addr` = 14'h12F0, `vid_scroll` = 8'h20, `vid_page` = 1, edge on `vid_drq` → `sram_addr` = 18'h05210 during READ; `vid_data` = `sram_dq_i` from cycle 3.
- **CPU byte write:** `cpu_wr` = 1, `cpu_msb` = 1, `cpu_addr` = 18'h00100 in IDLE → `we_n` = 0, `ub_n` = 0, `lb_n` = 1, `dq_oe_hi` = 1, `dq_oe_lo` = 0. The same request held during SETUP gives `we_n` = 1.
- **Tick deferral:** `cpu_tick` in SETUP → `cpu_ce` = 0 through HOLD, then `cpu_ce` = 1 for exactly one cycle in IDLE (cycle 4). Two ticks in one slot → one `cpu_ce`; `stat_drop` = 1 when `B2M_ARB_STATS_EN` is defined.
- **Back-to-back video:** second `vid_drq` edge during READ → `vpend` set; the new slot starts right after HOLD; `vid_busy` stays high except for one IDLE cycle.
- **Coincident events in IDLE:** `edge` and `cpu_tick` in the same IDLE cycle → `cpu_ce` = 1 that cycle; SETUP on the next cycle.

Source files
------------

// File: rtl/b2m_sram_arbiter.sv
// ---------------------------------------------------------------------------
// b2m_sram_arbiter
//
// Shares the single 16-bit board SRAM between the 8080 CPU port and the
// video line-fetch DMA of the Bashkiria-2M replica. Each video fetch runs as
// a fixed slot (IDLE -> SETUP -> READ x RD_WAIT -> HOLD -> IDLE). The CPU
// clock-enable is gated so that no CPU bus cycle overlaps a slot. At most one
// CPU tick lost to a slot is deferred to the following IDLE cycle.
//
// Parameters
//   RD_WAIT        number of READ cycles per slot (1..3), data captured on last
//
// Ports
//   clk50, reset   system clock, asynchronous active-high reset
//   vid_drq        video fetch request (rising edge = one slot)
//   vid_addr       video word address
//   vid_scroll     added (mod 256) to vid_addr[7:0]
//   vid_page       video bank, SRAM address bit 14
//   vid_data       captured video word
//   vid_busy       high whenever a slot is in progress
//   cpu_tick       raw CPU clock-enable pulses
//   cpu_ce         gated CPU clock-enable
//   cpu_addr       mapped CPU SRAM word address
//   cpu_msb        byte lane select (1 = DQ[15:8])
//   cpu_rd/cpu_wr  CPU memory read / qualified write
//   cpu_dout       CPU write data
//   cpu_din        selected SRAM byte (combinational)
//   sram_*         SRAM pins (split data bus with per-byte drive enables)
//
// Configuration
//   B2M_ARB_STATS_EN  when defined, adds stat_drop (saturating count of
//                     dropped ticks + dropped video edges) and stat_stall
//                     (wrapping count of cycles with a deferred tick).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module b2m_sram_arbiter #(
    parameter int RD_WAIT = 1
) (
    input  logic        clk50,
    input  logic        reset,
    // video DMA side
    input  logic        vid_drq,
    input  logic [13:0] vid_addr,
    input  logic [7:0]  vid_scroll,
    input  logic        vid_page,
    output logic [15:0] vid_data,
    output logic        vid_busy,
    // CPU side
    input  logic        cpu_tick,
    output logic        cpu_ce,
    input  logic [17:0] cpu_addr,
    input  logic        cpu_msb,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    // SRAM pins
    input  logic [15:0] sram_dq_i,
    output logic [15:0] sram_dq_o,
    output logic        sram_dq_oe_hi,
    output logic        sram_dq_oe_lo,
    output logic [17:0] sram_addr,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic        sram_we_n,
    output logic        sram_oe_n
`ifdef B2M_ARB_STATS_EN
    ,
    output logic [7:0]  stat_drop,
    output logic [15:0] stat_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        READ  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [1:0] rd_cnt, rd_cnt_nx;
    logic       vid_drq_q;
    logic       vpend, vpend_nx;
    logic       tpend, tpend_nx;

    logic       drq_edge;
    logic       in_idle;
    logic       in_read;
    logic       last_read;
    logic [7:0] vid_lo;

    assign drq_edge  = vid_drq & ~vid_drq_q;
    assign in_idle   = (state == IDLE);
    assign in_read   = (state == READ);
    assign last_read = in_read && (rd_cnt == 2'd0);

    // ------------------------------------------------------------------
    // State and pending-flag registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rd_cnt    <= 2'd0;
            vid_drq_q <= 1'b0;
            vpend     <= 1'b0;
            tpend     <= 1'b0;
            vid_data  <= 16'h0000;
        end else begin
            state     <= state_nx;
            rd_cnt    <= rd_cnt_nx;
            vid_drq_q <= vid_drq;
            vpend     <= vpend_nx;
            tpend     <= tpend_nx;
            if (last_read) begin
                vid_data <= sram_dq_i;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state, pending-flag and CPU enable logic
    // ------------------------------------------------------------------
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx  = state;
        rd_cnt_nx = rd_cnt;
        vpend_nx  = vpend;
        tpend_nx  = tpend;
        cpu_ce    = 1'b0;

        unique case (state)
            IDLE: begin
                // The CPU cycle completes here even if a slot starts next.
                cpu_ce   = cpu_tick | tpend;
                tpend_nx = 1'b0;
                vpend_nx = 1'b0;
                if (drq_edge || vpend) begin
                    state_nx = SETUP;
                end
            end
            SETUP: begin
                state_nx  = READ;
                rd_cnt_nx = 2'(RD_WAIT - 1);
            end
            READ: begin
                if (rd_cnt == 2'd0) begin
                    state_nx = HOLD;
                end else begin
                    rd_cnt_nx = rd_cnt - 2'd1;
                end
            end
            HOLD: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        // Requests arriving mid-slot are remembered once; repeats are lost.
        if (!in_idle) begin
            if (drq_edge) vpend_nx = 1'b1;
            if (cpu_tick) tpend_nx = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // SRAM pin drive
    // ------------------------------------------------------------------
    // Scroll wraps inside the 256-word line; no carry into the row bits.
    assign vid_lo    = vid_addr[7:0] + vid_scroll;

    assign sram_addr = in_read ? {3'b000, vid_page, vid_addr[13:8], vid_lo}
                               : cpu_addr;
    assign sram_ub_n = in_read ? 1'b0 : ~cpu_msb;
    assign sram_lb_n = in_read ? 1'b0 : cpu_msb;

    // Writes only ever happen in IDLE, so the strobe and the address can
    // change together only at a slot boundary.
    assign sram_we_n     = ~(cpu_wr & in_idle);
    assign sram_dq_oe_hi = ~sram_we_n & cpu_msb;
    assign sram_dq_oe_lo = ~sram_we_n & ~cpu_msb;
    assign sram_dq_o     = {cpu_dout, cpu_dout};
    assign sram_oe_n     = ~(in_read | (cpu_rd & in_idle));

    assign cpu_din  = cpu_msb ? sram_dq_i[15:8] : sram_dq_i[7:0];
    assign vid_busy = ~in_idle;

`ifdef B2M_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
    logic [1:0] drop_inc;
    logic [8:0] drop_sum;

    // A video edge and a CPU tick can both be lost in the same cycle.
    assign drop_inc = {1'b0, drq_edge & vpend} + {1'b0, cpu_tick & tpend};
    assign drop_sum = {1'b0, stat_drop} + {7'b0, drop_inc};

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            stat_drop  <= 8'h00;
            stat_stall <= 16'h0000;
        end else begin
            stat_drop <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            if (tpend) begin
                stat_stall <= stat_stall + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_b2m_sram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_b2m_sram_arbiter
//
// Directed scenarios followed by a randomized phase. Every cycle the DUT
// outputs are compared with a behavioural model that tracks the slot as a
// position counter (-1 = idle, 0 = setup, 1..RD_WAIT = read, RD_WAIT+1 =
// hold) plus the two pending flags.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_b2m_sram_arbiter;

    localparam int RDW = 1;

    logic        clk50 = 1'b0;
    logic        reset;
    logic        vid_drq;
    logic [13:0] vid_addr;
    logic [7:0]  vid_scroll;
    logic        vid_page;
    logic [15:0] vid_data;
    logic        vid_busy;
    logic        cpu_tick;
    logic        cpu_ce;
    logic [17:0] cpu_addr;
    logic        cpu_msb;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic [15:0] sram_dq_i;
    logic [15:0] sram_dq_o;
    logic        sram_dq_oe_hi;
    logic        sram_dq_oe_lo;
    logic [17:0] sram_addr;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_we_n;
    logic        sram_oe_n;
`ifdef B2M_ARB_STATS_EN
    logic [7:0]  stat_drop;
    logic [15:0] stat_stall;
`endif

    b2m_sram_arbiter #(.RD_WAIT(RDW)) dut (
        .clk50         (clk50),
        .reset         (reset),
        .vid_drq       (vid_drq),
        .vid_addr      (vid_addr),
        .vid_scroll    (vid_scroll),
        .vid_page      (vid_page),
        .vid_data      (vid_data),
        .vid_busy      (vid_busy),
        .cpu_tick      (cpu_tick),
        .cpu_ce        (cpu_ce),
        .cpu_addr      (cpu_addr),
        .cpu_msb       (cpu_msb),
        .cpu_rd        (cpu_rd),
        .cpu_wr        (cpu_wr),
        .cpu_dout      (cpu_dout),
        .cpu_din       (cpu_din),
        .sram_dq_i     (sram_dq_i),
        .sram_dq_o     (sram_dq_o),
        .sram_dq_oe_hi (sram_dq_oe_hi),
        .sram_dq_oe_lo (sram_dq_oe_lo),
        .sram_addr     (sram_addr),
        .sram_ub_n     (sram_ub_n),
        .sram_lb_n     (sram_lb_n),
        .sram_we_n     (sram_we_n),
        .sram_oe_n     (sram_oe_n)
`ifdef B2M_ARB_STATS_EN
        ,
        .stat_drop     (stat_drop),
        .stat_stall    (stat_stall)
`endif
    );

    always #5 clk50 = ~clk50;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          m_pos;
    bit          m_vpend;
    bit          m_tpend;
    bit          m_drq_q;
    logic [15:0] m_vdata;
    int          m_drop;
    int          m_stall;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_pos   = -1;
        m_vpend = 0;
        m_tpend = 0;
        m_drq_q = 0;
        m_vdata = 16'h0000;
        m_drop  = 0;
        m_stall = 0;
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_all(input string tag);
        bit          idle;
        bit          rd;
        bit          exp_we_n;
        int          lo;
        logic [17:0] exp_addr;
        idle     = (m_pos < 0);
        rd       = (m_pos >= 1) && (m_pos <= RDW);
        lo       = (int'(vid_addr[7:0]) + int'(vid_scroll)) % 256;
        exp_addr = rd ? 18'(int'(vid_page) * 16384 + int'(vid_addr[13:8]) * 256 + lo)
                      : cpu_addr;
        exp_we_n = !(cpu_wr && idle);
        check({tag, ".busy"},  32'(vid_busy),      32'(!idle));
        check({tag, ".ce"},    32'(cpu_ce),        32'(idle && (cpu_tick || m_tpend)));
        check({tag, ".vdata"}, 32'(vid_data),      32'(m_vdata));
        check({tag, ".addr"},  32'(sram_addr),     32'(exp_addr));
        check({tag, ".ub_n"},  32'(sram_ub_n),     32'(rd ? 1'b0 : !cpu_msb));
        check({tag, ".lb_n"},  32'(sram_lb_n),     32'(rd ? 1'b0 : cpu_msb));
        check({tag, ".we_n"},  32'(sram_we_n),     32'(exp_we_n));
        check({tag, ".oe_hi"}, 32'(sram_dq_oe_hi), 32'(!exp_we_n && cpu_msb));
        check({tag, ".oe_lo"}, 32'(sram_dq_oe_lo), 32'(!exp_we_n && !cpu_msb));
        check({tag, ".oe_n"},  32'(sram_oe_n),     32'(!(rd || (cpu_rd && idle))));
        check({tag, ".dq_o"},  32'(sram_dq_o),     32'({cpu_dout, cpu_dout}));
        check({tag, ".din"},   32'(cpu_din),
              32'(cpu_msb ? sram_dq_i[15:8] : sram_dq_i[7:0]));
`ifdef B2M_ARB_STATS_EN
        check({tag, ".sdrop"},  32'(stat_drop),  32'(m_drop));
        check({tag, ".sstall"}, 32'(stat_stall), 32'(m_stall % 65536));
`endif
    endtask

    // Advance the model by one clock using the inputs seen at the edge.
    task automatic m_update();
        bit idle;
        bit rise;
        if (reset) begin
            m_reset();
            return;
        end
        idle = (m_pos < 0);
        rise = vid_drq && !m_drq_q;
        if (m_pos == RDW) m_vdata = sram_dq_i;
        if (m_tpend) m_stall++;
        if (rise && m_vpend && m_drop < 255) m_drop++;
        if (cpu_tick && m_tpend && m_drop < 255) m_drop++;
        if (idle) begin
            m_tpend = 0;
            if (rise || m_vpend) begin
                m_pos   = 0;
                m_vpend = 0;
            end
        end else begin
            if (rise) m_vpend = 1;
            if (cpu_tick) m_tpend = 1;
            m_pos = (m_pos == RDW + 1) ? -1 : m_pos + 1;
        end
        m_drq_q = vid_drq;
    endtask

    // Called near the falling edge with inputs already set.
    task automatic cycle(input string tag);
        #1;
        check_all(tag);
        @(posedge clk50);
        m_update();
        @(negedge clk50);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit prev_tick;

        reset      = 1'b1;
        vid_drq    = 1'b0;
        vid_addr   = '0;
        vid_scroll = '0;
        vid_page   = 1'b0;
        cpu_tick   = 1'b0;
        cpu_addr   = '0;
        cpu_msb    = 1'b0;
        cpu_rd     = 1'b0;
        cpu_wr     = 1'b0;
        cpu_dout   = '0;
        sram_dq_i  = '0;
        m_reset();

        // ---- reset state ----
        repeat (2) @(negedge clk50);
        #1;
        check("rst.busy",  32'(vid_busy),  32'd0);
        check("rst.vdata", 32'(vid_data),  32'd0);
        check("rst.we_n",  32'(sram_we_n), 32'd1);
        check("rst.oe_n",  32'(sram_oe_n), 32'd1);
        check("rst.ce",    32'(cpu_ce),    32'd0);
        reset = 1'b0;
        cycle("idle0");
        cycle("idle1");

        // ---- video fetch with scroll wrap ----
        vid_addr   = 14'h12F0;
        vid_scroll = 8'h20;
        vid_page   = 1'b1;
        sram_dq_i  = 16'hBEEF;
        vid_drq    = 1'b1;
        cycle("vf.c0");
        #1 check("vf.busy_setup", 32'(vid_busy), 32'd1);
        cycle("vf.c1");
        #1 check("vf.addr", 32'(sram_addr), 32'h05210);
        check("vf.ub_n", 32'(sram_ub_n), 32'd0);
        check("vf.lb_n", 32'(sram_lb_n), 32'd0);
        check("vf.oe_n", 32'(sram_oe_n), 32'd0);
        cycle("vf.c2");
        sram_dq_i = 16'h1234;
        #1 check("vf.data", 32'(vid_data), 32'hBEEF);
        cycle("vf.c3");
        vid_drq = 1'b0;
        cycle("vf.c4");
        cycle("vf.c5");

        // ---- CPU byte write, then held into SETUP ----
        cpu_wr   = 1'b1;
        cpu_msb  = 1'b1;
        cpu_addr = 18'h00100;
        cpu_dout = 8'hA5;
        #1 check("wr.we_n", 32'(sram_we_n), 32'd0);
        check("wr.ub_n",  32'(sram_ub_n),     32'd0);
        check("wr.lb_n",  32'(sram_lb_n),     32'd1);
        check("wr.oe_hi", 32'(sram_dq_oe_hi), 32'd1);
        check("wr.oe_lo", 32'(sram_dq_oe_lo), 32'd0);
        check("wr.addr",  32'(sram_addr),     32'h00100);
        check("wr.dq_o",  32'(sram_dq_o),     32'hA5A5);
        vid_drq = 1'b1;
        cycle("wr.c0");
        #1 check("wr.setup_we_n", 32'(sram_we_n), 32'd1);
        check("wr.setup_oe_hi", 32'(sram_dq_oe_hi), 32'd0);
        cycle("wr.c1");
        cpu_wr  = 1'b0;
        vid_drq = 1'b0;
        repeat (3) cycle("wr.tail");

        // ---- single tick deferred across a slot ----
        vid_drq = 1'b1;
        cycle("td.c0");
        cpu_tick = 1'b1;
        #1 check("td.ce_setup", 32'(cpu_ce), 32'd0);
        cycle("td.c1");
        cpu_tick = 1'b0;
        vid_drq  = 1'b0;
        #1 check("td.ce_read", 32'(cpu_ce), 32'd0);
        cycle("td.c2");
        #1 check("td.ce_hold", 32'(cpu_ce), 32'd0);
        cycle("td.c3");
        #1 check("td.ce_idle", 32'(cpu_ce), 32'd1);
        cycle("td.c4");
        #1 check("td.ce_after", 32'(cpu_ce), 32'd0);
        cycle("td.c5");

        // ---- two ticks in one slot -> one enable, one drop ----
        vid_drq = 1'b1;
        cycle("tt.c0");
        cpu_tick = 1'b1;
        cycle("tt.c1");
        cpu_tick = 1'b0;
        vid_drq  = 1'b0;
        cycle("tt.c2");
        cpu_tick = 1'b1;
        #1 check("tt.ce_hold", 32'(cpu_ce), 32'd0);
        cycle("tt.c3");
        cpu_tick = 1'b0;
        #1 check("tt.ce_idle", 32'(cpu_ce), 32'd1);
        cycle("tt.c4");
        #1 check("tt.ce_after", 32'(cpu_ce), 32'd0);
`ifdef B2M_ARB_STATS_EN
        check("tt.stat_drop", 32'(stat_drop), 32'd1);
`endif
        cycle("tt.c5");

        // ---- back-to-back video with deferred tick at the seam ----
        vid_drq = 1'b1;
        #1 check("bb.busy0", 32'(vid_busy), 32'd0);
        cycle("bb.c0");
        vid_drq = 1'b0;
        #1 check("bb.busy1", 32'(vid_busy), 32'd1);
        cycle("bb.c1");
        vid_drq  = 1'b1;
        cpu_tick = 1'b1;
        #1 check("bb.busy2", 32'(vid_busy), 32'd1);
        cycle("bb.c2");
        vid_drq  = 1'b0;
        cpu_tick = 1'b0;
        #1 check("bb.busy3", 32'(vid_busy), 32'd1);
        cycle("bb.c3");
        #1 check("bb.busy4", 32'(vid_busy), 32'd0);
        check("bb.ce4", 32'(cpu_ce), 32'd1);
        cycle("bb.c4");
        #1 check("bb.busy5", 32'(vid_busy), 32'd1);
        check("bb.ce5", 32'(cpu_ce), 32'd0);
        cycle("bb.c5");
        cycle("bb.c6");
        cycle("bb.c7");
        #1 check("bb.busy8", 32'(vid_busy), 32'd0);
        cycle("bb.c8");

        // ---- edge and tick in the same IDLE cycle ----
        vid_drq  = 1'b1;
        cpu_tick = 1'b1;
        #1 check("co.ce", 32'(cpu_ce), 32'd1);
        check("co.busy0", 32'(vid_busy), 32'd0);
        cycle("co.c0");
        cpu_tick = 1'b0;
        #1 check("co.busy1", 32'(vid_busy), 32'd1);
        check("co.ce1", 32'(cpu_ce), 32'd0);
        cycle("co.c1");
        vid_drq = 1'b0;
        repeat (3) cycle("co.tail");

        // ---- reset asserted mid-READ ----
        vid_drq   = 1'b1;
        sram_dq_i = 16'h5A5A;
        cycle("rr.c0");
        cycle("rr.c1");
        vid_drq = 1'b0;
        #1 check("rr.in_read_oe_n", 32'(sram_oe_n), 32'd0);
        reset = 1'b1;
        m_reset();
        #1 check("rr.busy", 32'(vid_busy), 32'd0);
        check("rr.vdata", 32'(vid_data),  32'd0);
        check("rr.we_n",  32'(sram_we_n), 32'd1);
        check("rr.ce",    32'(cpu_ce),    32'd0);
        @(negedge clk50);
        cycle("rr.held");
        reset = 1'b0;
        repeat (4) cycle("rr.after");
        #1 check("rr.no_replay", 32'(vid_busy), 32'd0);
        check("rr.vdata_kept", 32'(vid_data), 32'd0);

        // ---- randomized traffic ----
        prev_tick = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) vid_drq = ~vid_drq;
            cpu_tick   = !prev_tick && ($urandom_range(0, 3) == 0);
            prev_tick  = cpu_tick;
            vid_addr   = 14'($urandom);
            vid_scroll = 8'($urandom);
            vid_page   = 1'($urandom);
            cpu_addr   = 18'($urandom);
            cpu_msb    = 1'($urandom);
            cpu_rd     = 1'($urandom);
            cpu_wr     = ($urandom_range(0, 3) == 0);
            cpu_dout   = 8'($urandom);
            sram_dq_i  = 16'($urandom);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
